sharpen3x3_stream: RTL

Streaming 3x3 sharpen/edge filter for 3-channel RGB video. It replaces the window-fed enhancement stage: it owns its two line buffers and its column/row tracking, and takes one pixel per valid cycle from the capture path. Channel width, line length and filter mode are selectable. Results are saturated per channel and emitted at a fixed pipeline latency.

---
 rtl/sharpen3x3_stream.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sharpen3x3_stream.sv
// Streaming 3x3 sharpen/edge filter for RGB video with internal line buffers.
// Three-stage pipeline: window capture, arithmetic, saturate/border.
module sharpen3x3_stream #(
  parameter int unsigned DW    = 8,
  parameter int unsigned IMG_W = 640
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IN_VALID,
  input  logic            IN_SOF,
  input  logic [3*DW-1:0] IN_DATA,
  input  logic [1:0]      MODE,
  output logic            OUT_VALID,
  output logic            OUT_SOF,
  output logic [3*DW-1:0] OUT_DATA
);

  localparam int unsigned PW = 3 * DW;
  localparam int unsigned AW = DW + 4;
  localparam int unsigned XW = $clog2(IMG_W);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);

  function automatic logic signed [AW-1:0] f_ext(input logic [DW-1:0] v);
    return $signed({4'b0000, v});
  endfunction

  // 4C - N - S - E - W; callers add C back for sharpen modes
  function automatic logic signed [AW-1:0] f_lap(input logic [DW-1:0] c, input logic [DW-1:0] n,
                                                 input logic [DW-1:0] s, input logic [DW-1:0] e,
                                                 input logic [DW-1:0] w);
    return (f_ext(c) <<< 2) - f_ext(n) - f_ext(s) - f_ext(e) - f_ext(w);
  endfunction

  function automatic logic [DW-1:0] f_grey(input logic [PW-1:0] p);
    logic [DW+1:0] sum;
    sum = (DW+2)'(p[2*DW +: DW]) + (DW+2)'(p[DW +: DW]) + (DW+2)'(p[0 +: DW]);
    return DW'(sum / (DW+2)'(3));
  endfunction

  function automatic logic [DW-1:0] f_sat(input logic signed [AW-1:0] v);
    if (v[AW-1]) return '0;
    if (|v[AW-2:DW]) return '1;
    return v[DW-1:0];
  endfunction

  logic [PW-1:0]   r_lb0 [IMG_W];
  logic [PW-1:0]   r_lb1 [IMG_W];
  logic [PW-1:0]   r_win [3][3];
  logic [XW-1:0]   r_x;
  logic [1:0]      r_y;
  logic            r_s1_valid, r_s1_sof, r_s1_border;
  logic [1:0]      r_s1_mode;
  logic            r_s2_valid, r_s2_sof, r_s2_border;
  logic signed [AW-1:0] r_s2_v [3];

  logic [XW-1:0]   w_px, w_nx;
  logic [1:0]      w_py, w_ny;

  // Position of the incoming pixel and of the one after it; SOF overrides wrap
  always_comb begin
    w_px = IN_SOF ? '0 : r_x;
    w_py = IN_SOF ? '0 : r_y;
    w_nx = w_px + XW'(1);
    w_ny = w_py;
    if (w_px == X_LAST) begin
      w_nx = '0;
      if (w_py != 2'd2) w_ny = w_py + 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (IN_VALID) begin
      r_lb1[w_px] <= r_lb0[w_px];
      r_lb0[w_px] <= IN_DATA;
    end
  end

  // Stage 1: counters, window shift and sideband capture
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_x         <= '0;
      r_y         <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_sof    <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_mode   <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_win[r][c] <= '0;
    end else begin
      r_s1_valid <= IN_VALID;
      if (IN_VALID) begin
        r_x         <= w_nx;
        r_y         <= w_ny;
        r_s1_sof    <= IN_SOF;
        r_s1_mode   <= MODE;
        r_s1_border <= (w_px < XW'(2)) || (w_py != 2'd2);
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= r_lb1[w_px];
        r_win[1][2] <= r_lb0[w_px];
        r_win[2][2] <= IN_DATA;
      end
    end
  end

  logic [PW-1:0]        w_c, w_n, w_s, w_e, w_w;
  logic [DW-1:0]        w_gc, w_gn, w_gs, w_ge, w_gw;
  logic signed [AW-1:0] w_tg;
  logic signed [AW-1:0] w_tch [3];
  logic signed [AW-1:0] w_v   [3];

  // Stage 2 arithmetic on the centred window
  always_comb begin
    w_c  = r_win[1][1];
    w_n  = r_win[0][1];
    w_s  = r_win[2][1];
    w_w  = r_win[1][0];
    w_e  = r_win[1][2];
    w_gc = f_grey(w_c);
    w_gn = f_grey(w_n);
    w_gs = f_grey(w_s);
    w_ge = f_grey(w_e);
    w_gw = f_grey(w_w);
    w_tg = f_lap(w_gc, w_gn, w_gs, w_ge, w_gw);
    for (int k = 0; k < 3; k++) begin
      w_tch[k] = f_lap(w_c[k*DW +: DW], w_n[k*DW +: DW], w_s[k*DW +: DW],
                       w_e[k*DW +: DW], w_w[k*DW +: DW]);
      w_v[k] = '0;
      case (r_s1_mode)
        2'd0:    w_v[k] = f_ext(w_c[k*DW +: DW]);
        2'd1:    w_v[k] = w_tch[k] + f_ext(w_c[k*DW +: DW]);
        2'd2:    w_v[k] = w_tg + f_ext(w_gc);
        default: w_v[k] = w_tg[AW-1] ? -w_tg : w_tg;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_s2_valid  <= 1'b0;
      r_s2_sof    <= 1'b0;
      r_s2_border <= 1'b0;
      for (int k = 0; k < 3; k++) r_s2_v[k] <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sof    <= r_s1_sof;
        r_s2_border <= r_s1_border;
        for (int k = 0; k < 3; k++) r_s2_v[k] <= w_v[k];
      end
    end
  end

  logic [PW-1:0] w_o;

  always_comb begin
    w_o = '0;
    for (int k = 0; k < 3; k++)
      w_o[k*DW +: DW] = r_s2_border ? '0 : f_sat(r_s2_v[k]);
  end

  // Stage 3: output registers, data forced to zero outside valid cycles
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      OUT_VALID <= 1'b0;
      OUT_SOF   <= 1'b0;
      OUT_DATA  <= '0;
    end else begin
      OUT_VALID <= r_s2_valid;
      OUT_SOF   <= r_s2_valid & r_s2_sof;
      OUT_DATA  <= r_s2_valid ? w_o : '0;
    end
  end

endmodule
